// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060208_sram_rd_arbiter
//  Description : Round-robin arbiter that shares one SRAM read port between
//                the IFU (master 0) and the LSU (master 1). Every side uses the
//                simplified AXI-lite read channels (AR and R). Only one
//                transaction is outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060208_sram_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // Master 0 (IFU)
  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,

  // Master 1 (LSU)
  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,

  // Slave (SRAM)
  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,

  // Debug: index of the master currently granted
  output logic                  owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic                  owner_q;
  logic                  owner_d;
  logic                  last_grant_q;
  logic                  last_grant_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] addr_d;

  logic                  w_any_req;
  logic                  w_grant_idx;
  logic                  w_r_done;

  // Winner selection: a lone requester wins outright; on a tie the master
  // that did not complete the previous transaction wins.
  always_comb begin
    w_any_req   = m0_arvalid | m1_arvalid;
    w_grant_idx = 1'b0;
    if (m0_arvalid && m1_arvalid) begin
      w_grant_idx = ~last_grant_q;
    end else if (m1_arvalid) begin
      w_grant_idx = 1'b1;
    end
  end

  // Next-state logic plus all handshake and routing outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;

    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_rresp     = 2'b00;
    m1_rresp     = 2'b00;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    w_r_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Accept the winner's AR in this cycle; gated by reset so that no
        // handshake can be seen while the block is being reset.
        if (!rst && w_any_req) begin
          m0_arready = ~w_grant_idx;
          m1_arready =  w_grant_idx;
          addr_d     = w_grant_idx ? m1_araddr : m0_araddr;
          owner_d    = w_grant_idx;
          state_d    = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // Forward the latched address; master address changes are ignored.
        s_arvalid = 1'b1;
        if (s_arready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // Route the R channel to the owner only; the other master sees zeros.
        if (owner_q == 1'b0) begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          s_rready  = m0_rready;
        end else begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          s_rready  = m1_rready;
        end
        w_r_done = s_rvalid & s_rready;
        if (w_r_done) begin
          // Round-robin history moves only when the data beat completes.
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_araddr = addr_q;
  assign owner    = owner_q;

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_23060208_sram_rd_arbiter
//  Description : Directed self-checking bench for the two-master SRAM read
//                arbiter, with a small SRAM slave model of adjustable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060208_sram_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        owner;

  int errors = 0;
  int checks = 0;

  ysyx_23060208_sram_rd_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM slave model ----------------
  int          ar_delay = 0;   // cycles s_arvalid is seen before s_arready rises
  int          r_delay  = 2;   // cycles between AR handshake and s_rvalid
  logic [1:0]  sl_resp  = 2'b00;
  logic [1:0]  sl_st;
  int          sl_wait;
  int          sl_cnt;
  logic [31:0] sl_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_rd = 32'h0000_0413;
      32'h8000_0004: mem_rd = 32'h0000_0293;
      32'h8000_0010: mem_rd = 32'h1111_1111;
      32'h8000_0020: mem_rd = 32'h2222_2222;
      32'h8000_0100: mem_rd = 32'hDEAD_BEEF;
      default:       mem_rd = ~a;
    endcase
  endfunction

  assign s_arready = (sl_st == 2'd0) && (sl_wait >= ar_delay);
  assign s_rvalid  = (sl_st == 2'd2);
  assign s_rdata   = (sl_st == 2'd2) ? mem_rd(sl_addr) : 32'h0;
  assign s_rresp   = (sl_st == 2'd2) ? sl_resp : 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      sl_st   <= 2'd0;
      sl_wait <= 0;
      sl_cnt  <= 0;
      sl_addr <= 32'h0;
    end else begin
      case (sl_st)
        2'd0: begin
          if (s_arvalid && s_arready) begin
            sl_addr <= s_araddr;
            sl_wait <= 0;
            if (r_delay == 0) sl_st <= 2'd2;
            else begin sl_st <= 2'd1; sl_cnt <= r_delay; end
          end else if (s_arvalid) begin
            sl_wait <= sl_wait + 1;
          end
        end
        2'd1: begin
          if (sl_cnt <= 1) sl_st <= 2'd2;
          else sl_cnt <= sl_cnt - 1;
        end
        2'd2: if (s_rready) sl_st <= 2'd0;
        default: sl_st <= 2'd0;
      endcase
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Waits for rvalid on master m, noting whether the other master saw rvalid.
  task automatic wait_rv(input bit m, output int n, output bit seen, output bit leak);
    n = 0; seen = 1'b0; leak = 1'b0;
    while (!seen && n < 30) begin
      tick; n++;
      @(negedge clk);
      if (m ? m0_rvalid : m1_rvalid) leak = 1'b1;
      if (m ? m1_rvalid : m0_rvalid) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    m0_araddr = 32'h8000_0000; m1_araddr = 32'h8000_0004;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m0_arready !== 1'b0) begin errors++; $display("FAIL reset_m0_arready: got %b want 0", m0_arready); end
    checks++; if (m1_arready !== 1'b0) begin errors++; $display("FAIL reset_m1_arready: got %b want 0", m1_arready); end
    checks++; if (s_arvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL reset_slave: arvalid=%b rready=%b want 0 0", s_arvalid, s_rready); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: m0=%b m1=%b want 0 0", m0_rvalid, m1_rvalid); end
    checks++; if (owner !== 1'b0 || s_araddr !== 32'h0) begin errors++; $display("FAIL reset_regs: owner=%b addr=%h want 0 0", owner, s_araddr); end
    tick;
    rst = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_m0_only;
    int n; bit seen, leak;
    tick;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL m0only_arready: m0=%b m1=%b want 1 0", m0_arready, m1_arready); end
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL m0only_arvalid_c0: got %b want 0", s_arvalid); end
    tick;
    m0_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL m0only_ar_c1: valid=%b addr=%h want 1 80000000", s_arvalid, s_araddr); end
    wait_rv(1'b0, n, seen, leak);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL m0only_timeout: rvalid seen=%b want 1", seen); end
    checks++; if (n !== 3) begin errors++; $display("FAIL m0only_latency: rvalid %0d cycles after s_arvalid want 3", n); end
    checks++; if (m0_rdata !== 32'h0000_0413 || m0_rresp !== 2'b00) begin errors++; $display("FAIL m0only_rdata: got %h/%b want 00000413/00", m0_rdata, m0_rresp); end
    checks++; if (leak !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL m0only_m1_rvalid: leak=%b want 0", leak); end
    tick;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL m0only_done: rvalid=%b rready=%b want 0 0", m0_rvalid, s_rready); end
  endtask

  task automatic test_m1_only;
    int n; bit seen, leak;
    tick;
    sl_resp = 2'b10;
    m1_araddr = 32'h8000_0100; m1_arvalid = 1'b1; m1_rready = 1'b1;
    @(negedge clk);
    checks++; if (m1_arready !== 1'b1 || m0_arready !== 1'b0) begin errors++; $display("FAIL m1only_arready: m1=%b m0=%b want 1 0", m1_arready, m0_arready); end
    tick;
    m1_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (owner !== 1'b1 || s_araddr !== 32'h8000_0100) begin errors++; $display("FAIL m1only_owner: owner=%b addr=%h want 1 80000100", owner, s_araddr); end
    wait_rv(1'b1, n, seen, leak);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL m1only_timeout: rvalid seen=%b want 1", seen); end
    checks++; if (m1_rdata !== 32'hDEAD_BEEF || m1_rresp !== 2'b10) begin errors++; $display("FAIL m1only_rdata: got %h/%b want deadbeef/10", m1_rdata, m1_rresp); end
    checks++; if (leak !== 1'b0 || m0_rdata !== 32'h0 || m0_rresp !== 2'b00) begin errors++; $display("FAIL m1only_nonowner: leak=%b rdata=%h resp=%b want 0 0 0", leak, m0_rdata, m0_rresp); end
    checks++; if (owner !== 1'b1 || s_rready !== 1'b1) begin errors++; $display("FAIL m1only_data: owner=%b s_rready=%b want 1 1", owner, s_rready); end
    sl_resp = 2'b00;
    tick;
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    int n; bit seen, leak;
    tick;
    m0_araddr = 32'h8000_0000; m1_araddr = 32'h8000_0004;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL sim_first: m0=%b m1=%b want 1 0", m0_arready, m1_arready); end
    tick;
    m0_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (m1_arready !== 1'b0) begin errors++; $display("FAIL sim_loser_wait: m1_arready=%b want 0", m1_arready); end
    wait_rv(1'b0, n, seen, leak);
    checks++; if (seen !== 1'b1 || m0_rdata !== 32'h0000_0413) begin errors++; $display("FAIL sim_m0_data: seen=%b rdata=%h want 1 00000413", seen, m0_rdata); end
    tick;
    @(negedge clk);
    checks++; if (m1_arready !== 1'b1 || m0_arready !== 1'b0) begin errors++; $display("FAIL sim_second: m1=%b m0=%b want 1 0", m1_arready, m0_arready); end
    tick;
    m1_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (owner !== 1'b1 || s_araddr !== 32'h8000_0004) begin errors++; $display("FAIL sim_m1_ar: owner=%b addr=%h want 1 80000004", owner, s_araddr); end
    wait_rv(1'b1, n, seen, leak);
    checks++; if (seen !== 1'b1 || m1_rdata !== 32'h0000_0293) begin errors++; $display("FAIL sim_m1_data: seen=%b rdata=%h want 1 00000293", seen, m1_rdata); end
    tick;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL sim_alternate: m0=%b m1=%b want 1 0", m0_arready, m1_arready); end
    tick;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    wait_rv(1'b0, n, seen, leak);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sim_third_timeout: seen=%b want 1", seen); end
    tick;
    @(negedge clk);
  endtask

  task automatic test_addr_change;
    int n; bit seen, leak;
    tick;
    m1_araddr = 32'h8000_0010; m1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (m1_arready !== 1'b1) begin errors++; $display("FAIL addrchg_grant: m1_arready=%b want 1", m1_arready); end
    tick;
    m1_araddr = 32'h8000_0020; m1_arvalid = 1'b0;
    @(negedge clk);
    checks++; if (s_araddr !== 32'h8000_0010) begin errors++; $display("FAIL addrchg_araddr: got %h want 80000010", s_araddr); end
    wait_rv(1'b1, n, seen, leak);
    checks++; if (seen !== 1'b1 || m1_rdata !== 32'h1111_1111 || s_araddr !== 32'h8000_0010) begin errors++; $display("FAIL addrchg_data: seen=%b rdata=%h addr=%h want 1 11111111 80000010", seen, m1_rdata, s_araddr); end
    tick;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit hold_bad;
    hold_bad = 1'b0;
    tick;
    ar_delay = 3; r_delay = 2;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b0;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b1) begin errors++; $display("FAIL bp_grant: m0_arready=%b want 1", m0_arready); end
    tick;
    m0_arvalid = 1'b0; m0_araddr = 32'h8000_0004;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick;
      @(negedge clk);
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) hold_bad = 1'b1;
    end
    checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL bp_ar_hold: unstable=%b want 0", hold_bad); end
    tick;
    @(negedge clk);
    checks++; if (s_arvalid !== 1'b0 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL bp_data_entry: arvalid=%b rvalid=%b want 0 0", s_arvalid, m0_rvalid); end
    tick;
    tick;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || s_rready !== 1'b0) begin errors++; $display("FAIL bp_stall1: rvalid=%b rready=%b want 1 0", m0_rvalid, s_rready); end
    tick;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || s_rready !== 1'b0) begin errors++; $display("FAIL bp_stall2: rvalid=%b rready=%b want 1 0", m0_rvalid, s_rready); end
    tick;
    m0_rready = 1'b1;
    @(negedge clk);
    checks++; if (s_rready !== 1'b1 || m0_rdata !== 32'h0000_0413) begin errors++; $display("FAIL bp_release: rready=%b rdata=%h want 1 00000413", s_rready, m0_rdata); end
    tick;
    ar_delay = 0;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL bp_complete: rvalid=%b rready=%b want 0 0", m0_rvalid, s_rready); end
  endtask

  task automatic test_reset_mid_data;
    int n; bit seen, leak, late;
    late = 1'b0;
    tick;
    r_delay = 4;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    tick;
    m0_arvalid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b0 || m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL rstmid_ar: m0=%b m1=%b s=%b want 0 0 0", m0_arready, m1_arready, s_arvalid); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || s_rready !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL rstmid_r: m0v=%b m1v=%b rr=%b own=%b want 0 0 0 0", m0_rvalid, m1_rvalid, s_rready, owner); end
    for (int i = 0; i < 6; i++) begin
      tick;
      @(negedge clk);
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) late = 1'b1;
    end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL rstmid_stale_rvalid: seen=%b want 0", late); end
    tick;
    r_delay = 2;
    m0_araddr = 32'h8000_0004; m1_araddr = 32'h8000_0100;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    @(negedge clk);
    checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL rstmid_tie: m0=%b m1=%b want 1 0", m0_arready, m1_arready); end
    tick;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    wait_rv(1'b0, n, seen, leak);
    checks++; if (seen !== 1'b1 || m0_rdata !== 32'h0000_0293 || n !== 3) begin errors++; $display("FAIL rstmid_after: seen=%b rdata=%h n=%0d want 1 00000293 3", seen, m0_rdata, n); end
    tick;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_m0_only;
    test_m1_only;
    test_simultaneous;
    test_addr_change;
    test_backpressure;
    test_reset_mid_data;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
